// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Bit counter width; guarded so a degenerate width still yields a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_add_cell.sv
// Single-bit full adder cell, purely combinational.
module full_add_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first,
// producing {cout,sum} = a + b + cin after WIDTH shift cycles.
module serial_add
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             accept;
    logic             last_bit;

    full_add_cell u_fa (
        .x  (ra[0]),
        .y  (rb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // DONE accepts a new start just like IDLE so back-to-back adds lose no cycle.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? SHIFT : IDLE;
            SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
            DONE:    state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
        sum  = res;
        cout = carry;
    end

    // Result fills from the MSB end, so after WIDTH shifts bit 0 holds the first sum bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            ra    <= a;
            rb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            ra    <= {1'b0, ra[WIDTH-1:1]};
            rb    <= {1'b0, rb[WIDTH-1:1]};
            res   <= {fa_s, res[WIDTH-1:1]};
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// Scoreboard bench for serial_add: WIDTH=8 directed cases and WIDTH=4 exhaustive.
module tb_serial_add;

    logic       clk = 1'b0;
    logic       rst8, start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       rst4, start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] e8;
    logic [4:0] e4;

    always #5 clk = ~clk;

    serial_add #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done8_cnt++;
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL w8_unexpected_done got=%0h expected=none", {cout8, sum8});
            end else begin
                e8 = q8.pop_front();
                if ({cout8, sum8} !== e8) begin
                    failures++;
                    $display("FAIL w8_sum got=%0h expected=%0h", {cout8, sum8}, e8);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            done4_cnt++;
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL w4_unexpected_done got=%0h expected=none", {cout4, sum4});
            end else begin
                e4 = q4.pop_front();
                if ({cout4, sum4} !== e4) begin
                    failures++;
                    $display("FAIL w4_sum a=%0h b=%0h got=%0h expected=%0h", a4, b4, {cout4, sum4}, e4);
                end
            end
        end
    end

    // Drives start for one edge; returns just after the accepting edge.
    task automatic start8_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                             input logic [8:0] exp, input bit push);
        @(posedge clk); #1;
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        if (push) q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int n, output int nb);
        bit got = 0;
        n = 0; nb = 0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
            if (done8) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL w8_timeout got=no_done expected=done");
        end
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int n = 0;
        bit got = 0;
        @(posedge clk); #1;
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        q4.push_back({1'b0, ta} + {1'b0, tb} + {4'd0, tc});
        @(posedge clk); #1;
        start4 = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (done4) got = 1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL w4_timeout got=no_done expected=done");
        end
    endtask

    initial begin
        int n, nb, n2, dc0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);

        // Basic add with latency and busy-length checks
        start8_op(8'h3C, 8'h5A, 1'b0, 9'h096, 1);
        wait_done8(n, nb);
        chk("lat_done_cycle", n, 9);
        chk("busy_cycles", nb, 8);

        start8_op(8'hFF, 8'h01, 1'b0, 9'h100, 1);
        wait_done8(n, nb);
        start8_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1);
        wait_done8(n, nb);

        // sum/cout hold through IDLE
        repeat (3) @(negedge clk);
        chk("hold_sum", sum8, 8'hFF);
        chk("hold_cout", cout8, 1);

        // Start during SHIFT is ignored
        dc0 = done8_cnt;
        start8_op(8'h12, 8'h34, 1'b0, 9'h046, 1);
        repeat (3) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(n, nb);
        chk("ignored_start_lat", n, 6);
        repeat (15) @(negedge clk);
        chk("ignored_start_one_done", done8_cnt, dc0 + 1);

        // Reset mid-operation aborts without done
        start8_op(8'h77, 8'h88, 1'b1, 9'h0, 0);
        repeat (4) @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_cout", cout8, 0);
        dc0 = done8_cnt;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done8_cnt, dc0);

        // rst beats a simultaneous start
        @(posedge clk); #1;
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
        @(posedge clk); #1;
        rst8 = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("rst_wins_busy", busy8, 0);

        // Back-to-back: start held through the DONE cycle
        start8_op(8'h01, 8'h02, 1'b0, 9'h003, 1);
        wait_done8(n, nb);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        #1 q8.push_back(9'h030);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(n2, nb);
        chk("b2b_spacing", n2, 9);
        chk("b2b_sum", sum8, 8'h30);

        // WIDTH=4 exhaustive
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    run4(4'(i), 4'(j), 1'(k));
        repeat (4) @(negedge clk);
        chk("w4_done_count", done4_cnt, 512);
        chk("w4_queue_empty", q4.size(), 0);
        chk("w8_queue_empty", q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
